// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: 8N1 UART command receiver that issues one 32-bit bus read/write (clk_i, rst_i, uart_rx_i/uart_tx_o, bus_* req/gnt/rvalid initiator, busy_o, frame_err_o) and serialises the response
module uart_bus_bridge #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        busy_o,
  output logic        frame_err_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  localparam logic [TW-1:0] TO_END = TW'(TO);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, B_REQ, B_WAIT, T_RESP} p_state_t;
  logic rx_m, rx_s, rx_d;
  rx_state_t rx_st, rx_nx;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_left;
  logic [7:0] rx_sh;
  logic rx_tick, rx_done, rx_bad;
  p_state_t st, nx;
  logic [1:0] idx;
  logic we_q, tx_q, tx_tick, timeout, in_cmd, opc_ok;
  logic [31:0] addr_q, wdata_q, resp_q;
  logic [3:0] tx_bit;
  logic [TW-1:0] to_cnt;
  assign rx_tick = rx_cnt == (rx_st == R_START ? HALF_END : BIT_END);
  assign rx_done = rx_st == R_STOP && rx_tick && rx_s;
  assign rx_bad = rx_st == R_STOP && rx_tick && !rx_s;
  assign tx_tick = tx_cnt == BIT_END;
  assign timeout = to_cnt == TO_END;
  assign in_cmd = st == P_ADDR || st == P_DATA;
  assign opc_ok = rx_sh == 8'h01 || rx_sh == 8'h02;
  assign uart_tx_o = tx_q;
  assign bus_req_o = st == B_REQ;
  assign bus_we_o = we_q;
  assign bus_be_o = 4'hF;
  assign bus_addr_o = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o = st != P_IDLE;
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      R_IDLE:  if (rx_d && !rx_s) rx_nx = R_START;
      R_START: if (rx_tick) rx_nx = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_tick && rx_bit == 3'd7) rx_nx = R_STOP;
      default: if (rx_tick) rx_nx = R_IDLE;
    endcase
  end
  always_comb begin
    nx = st;
    case (st)
      P_IDLE: if (rx_done) nx = opc_ok ? P_ADDR : T_RESP;
      P_ADDR: if (rx_bad || timeout) nx = P_IDLE;
              else if (rx_done && idx == 2'd3) nx = we_q ? P_DATA : B_REQ;
      P_DATA: if (rx_bad || timeout) nx = P_IDLE;
              else if (rx_done && idx == 2'd3) nx = B_REQ;
      B_REQ:  if (bus_gnt_i) nx = B_WAIT;
      B_WAIT: if (bus_rvalid_i) nx = T_RESP;
      T_RESP: if (tx_tick && tx_bit == 4'd9 && tx_left == 3'd1) nx = P_IDLE;
      default: nx = P_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
      rx_st <= R_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_m <= uart_rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
      rx_st <= rx_nx;
      rx_cnt <= (rx_st == R_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_st == R_DATA && rx_tick) begin
        rx_sh <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st <= P_IDLE;
      frame_err_o <= 1'b0;
      idx <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_q <= '0;
      tx_q <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_left <= '0;
      to_cnt <= '0;
    end else begin
      st <= nx;
      frame_err_o <= rx_bad;
      to_cnt <= (rx_st != R_IDLE || !in_cmd) ? '0 : to_cnt + 1'b1;
      tx_cnt <= (st != T_RESP || tx_tick) ? '0 : tx_cnt + 1'b1;
      idx <= st == P_IDLE ? 2'd0 : (rx_done && in_cmd) ? idx + 2'd1 : idx;
      if (st == P_IDLE && rx_done && opc_ok) we_q <= rx_sh[1];
      if (st == P_ADDR && rx_done) addr_q[{idx, 3'b000} +: 8] <= idx == 2'd0 ? {rx_sh[7:2], 2'b00} : rx_sh;
      if (st == P_DATA && rx_done) wdata_q[{idx, 3'b000} +: 8] <= rx_sh;
      if (nx == T_RESP && st != T_RESP) begin
        resp_q <= st != B_WAIT ? 32'h0000_00EE : bus_err_i ? 32'h0000_00EE : we_q ? 32'h0000_00A5 : bus_rdata_i;
        tx_left <= (st == B_WAIT && !bus_err_i && !we_q) ? 3'd4 : 3'd1;
        tx_q <= 1'b0;
        tx_bit <= '0;
      end else if (st == T_RESP && tx_tick) begin
        tx_bit <= tx_bit == 4'd9 ? 4'd0 : tx_bit + 1'b1;
        tx_q <= tx_bit < 4'd8 ? resp_q[0] : (tx_bit == 4'd8 || tx_left == 3'd1);
        if (tx_bit < 4'd8) resp_q <= {1'b0, resp_q[31:1]};
        if (tx_bit == 4'd9) tx_left <= tx_left - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed table-driven bench for uart_bus_bridge with hand-written reset, frame-error and timeout sequences
module tb_uart_bus_bridge;
  localparam int CPB = 8;
  localparam int TOB = 16;
  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          d;
    logic        req;
    logic [31:0] exp_addr;
    int          nb;
    logic [31:0] tx;
  } vec_t;
  logic clk_i = 1'b0, rst_i = 1'b1, uart_rx_i = 1'b1;
  logic bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic uart_tx_o, bus_req_o, bus_we_o, busy_o, frame_err_o;
  logic [3:0] bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  int total = 0, bad = 0, req_hi = 0, fe_hi = 0;
  vec_t vt[7];
  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_rx_i(uart_rx_i), .uart_tx_o(uart_tx_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i), .busy_o(busy_o), .frame_err_o(frame_err_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) begin
    if (bus_req_o) req_hi++;
    if (frame_err_o) fe_hi++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    uart_rx_i = stop;
    repeat (CPB) @(negedge clk_i);
    uart_rx_i = 1'b1;
  endtask
  task automatic send_cmd(input vec_t v);
    send_byte(v.op, 1'b1);
    if (v.op == 8'h01 || v.op == 8'h02)
      for (int i = 0; i < 4; i++) send_byte(v.addr[8*i +: 8], 1'b1);
    if (v.op == 8'h02)
      for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8], 1'b1);
  endtask
  task automatic slave(input vec_t v, input logic rv);
    int n;
    n = 0;
    while (!bus_req_o && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    chk("req_seen", bus_req_o, 1'b1);
    if (!bus_req_o) return;
    chk("busy_in_cmd", busy_o, 1'b1);
    chk("bus_addr", bus_addr_o, v.exp_addr);
    chk("bus_we", bus_we_o, v.op == 8'h02);
    chk("bus_be", bus_be_o, 4'hF);
    if (v.op == 8'h02) chk("bus_wdata", bus_wdata_o, v.wdata);
    repeat (v.d) @(negedge clk_i);
    chk("req_held", bus_req_o, 1'b1);
    chk("addr_stable", bus_addr_o, v.exp_addr);
    bus_gnt_i = 1'b1;
    @(negedge clk_i);
    bus_gnt_i = 1'b0;
    chk("req_drop", bus_req_o, 1'b0);
    if (!rv) return;
    bus_rvalid_i = 1'b1;
    bus_rdata_i = v.rdata;
    bus_err_i = v.err;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    bus_err_i = 1'b0;
    bus_rdata_i = '0;
  endtask
  task automatic tx_mon(input int nb, input logic [31:0] exp);
    for (int k = 0; k < nb; k++) begin
      logic [7:0] r;
      int n;
      n = 0;
      while (uart_tx_o && n < 4000) begin
        @(negedge clk_i);
        n++;
      end
      if (uart_tx_o) begin
        chk("tx_start_timeout", uart_tx_o, 1'b0);
        return;
      end
      repeat (CPB / 2) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk_i);
        r[i] = uart_tx_o;
      end
      repeat (CPB) @(negedge clk_i);
      chk($sformatf("tx_stop%0d", k), uart_tx_o, 1'b1);
      chk($sformatf("tx_byte%0d", k), r, exp[8*k +: 8]);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int r0;
    r0 = req_hi;
    fork
      send_cmd(v);
      if (v.req) slave(v, 1'b1);
      tx_mon(v.nb, v.tx);
    join
    repeat (CPB) @(negedge clk_i);
    chk("req_cycles", req_hi - r0, v.req ? v.d + 1 : 0);
    chk("busy_after", busy_o, 1'b0);
    chk("tx_idle", uart_tx_o, 1'b1);
  endtask
  initial begin
    int r0, f0;
    vt[0] = '{8'h01, 32'h80000010, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b1, 32'h80000010, 4, 32'hDEADBEEF};
    vt[1] = '{8'h02, 32'hFFFFFFE4, 32'h00000041, 32'h0, 1'b0, 3, 1'b1, 32'hFFFFFFE4, 1, 32'h000000A5};
    vt[2] = '{8'h01, 32'h12345677, 32'h0, 32'h55555555, 1'b1, 1, 1'b1, 32'h12345674, 1, 32'h000000EE};
    vt[3] = '{8'h7F, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 1, 32'h000000EE};
    vt[4] = '{8'h02, 32'h00000003, 32'hCAFEF00D, 32'h0, 1'b0, 0, 1'b1, 32'h00000000, 1, 32'h000000A5};
    vt[5] = '{8'h01, 32'h00000104, 32'h0, 32'h00000000, 1'b0, 2, 1'b1, 32'h00000104, 4, 32'h00000000};
    vt[6] = '{8'h02, 32'h40000008, 32'h00000001, 32'h0, 1'b1, 1, 1'b1, 32'h40000008, 1, 32'h000000EE};
    repeat (5) @(negedge clk_i);
    chk("rst_tx", uart_tx_o, 1'b1);
    chk("rst_req", bus_req_o, 1'b0);
    chk("rst_we", bus_we_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_fe", frame_err_o, 1'b0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_wdata", bus_wdata_o, 32'h0);
    chk("rst_be", bus_be_o, 4'hF);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    for (int i = 0; i < 7; i++) run_vec(vt[i]);
    r0 = req_hi;
    f0 = fe_hi;
    send_byte(8'h01, 1'b0);
    repeat (4 * CPB) @(negedge clk_i);
    chk("fe_pulse", fe_hi - f0, 1);
    chk("fe_no_busy", busy_o, 1'b0);
    chk("fe_no_req", req_hi - r0, 0);
    run_vec(vt[0]);
    r0 = req_hi;
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    chk("to_busy_before", busy_o, 1'b1);
    repeat (17 * CPB) @(negedge clk_i);
    chk("to_busy", busy_o, 1'b0);
    chk("to_no_req", req_hi - r0, 0);
    run_vec(vt[1]);
    fork
      send_cmd(vt[0]);
      slave(vt[0], 1'b0);
    join
    repeat (3) @(negedge clk_i);
    chk("bwait_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("bwait_rst_req", bus_req_o, 1'b0);
    chk("bwait_rst_tx", uart_tx_o, 1'b1);
    chk("bwait_rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    fork
      send_cmd(vt[0]);
      slave(vt[0], 1'b1);
    join
    repeat (3 * CPB) @(negedge clk_i);
    chk("txrst_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("txrst_req", bus_req_o, 1'b0);
    chk("txrst_tx", uart_tx_o, 1'b1);
    chk("txrst_busy_after", busy_o, 1'b0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk_i);
    run_vec(vt[5]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
